instruction_fetch_unit: RTL

Per-tile instruction fetch stage sitting directly upstream of `program_memory`. It holds the program counter, issues sequential reads into the tile's program memory (1-cycle registered read latency), buffers returned words with their addresses, and presents them to the decoder over a valid/ready handshake. It also handles branch redirects and halt.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instruction_fetch_unit_if.sv | 35 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the per-tile instruction fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_DATA_WIDTH = 32;
   localparam int unsigned FETCH_ADDR_WIDTH = 12;
   localparam int unsigned FETCH_FIFO_DEPTH = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_ADDR_WIDTH-1:0] pc;
      logic [FETCH_DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control, program-memory and decoder-handshake signals of the fetch stage.
interface instruction_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] start_pc;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  halt;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read_en;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  busy;

   // Fetch unit side
   modport master (
      input  start, start_pc, redirect, redirect_pc, halt,
      input  mem_read_data, instr_ready,
      output mem_addr, mem_read_en, instr, instr_pc, instr_valid, busy
   );

   // Control, memory and decoder side
   modport slave (
      output start, start_pc, redirect, redirect_pc, halt,
      output mem_read_data, instr_ready,
      input  mem_addr, mem_read_en, instr, instr_pc, instr_valid, busy
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: head entry visible combinationally, flush clears
// pointers and overrides any push/pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type          entry_t = fetch_entry_t,
   parameter int unsigned  DEPTH   = FETCH_FIFO_DEPTH,
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  entry_t           wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output entry_t           head_o,
   output logic [CNT_W-1:0] count_o
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_c, do_pop_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A push into a full buffer is only legal when the head leaves the same cycle
   always_comb begin
      do_pop_c  = pop_i && (count_q != '0);
      do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while count is non-zero
   always_ff @(posedge clock) begin
      if (do_push_c && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited sequential reads into program
// memory, response buffering and redirect/halt handling.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = FETCH_ADDR_WIDTH,
   parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input logic                      clock,
   input logic                      reset,
   instruction_fetch_unit_if.master bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CRD_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                  inflight_q, inflight_d;

   logic                  issue_c, flush_c, push_c, pop_c, valid_c;
   logic [CRD_W-1:0]      credit_c;
   logic [CNT_W-1:0]      fifo_count_c;
   entry_t                head_c, wdata_c;

   assign valid_c  = (fifo_count_c != '0);
   assign pop_c    = valid_c && bus.instr_ready;
   // Slots already claimed once this cycle's pop is taken into account
   assign credit_c = CRD_W'(fifo_count_c) + CRD_W'(inflight_q) - CRD_W'(pop_c);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      issue_c       = 1'b0;
      flush_c       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               pc_d    = bus.start_pc;
            end
         end
         RUN: begin
            if (bus.halt) begin
               state_d = IDLE;
               flush_c = 1'b1;
            end else if (bus.redirect) begin
               flush_c = 1'b1;
               pc_d    = bus.redirect_pc;
            end else if (!reset && (credit_c < CRD_W'(FIFO_DEPTH))) begin
               issue_c       = 1'b1;
               pc_d          = pc_q + ADDR_WIDTH'(1);
               inflight_d    = 1'b1;
               inflight_pc_d = pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A response arriving in a flush cycle belongs to the abandoned stream
   assign push_c  = inflight_q && !flush_c;
   assign wdata_c = '{pc: inflight_pc_q, instr: bus.mem_read_data};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_c),
      .wdata_i (wdata_c),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .head_o  (head_c),
      .count_o (fifo_count_c)
   );

   assign bus.mem_addr    = pc_q;
   assign bus.mem_read_en = issue_c;
   assign bus.instr       = valid_c ? head_c.instr : '0;
   assign bus.instr_pc    = valid_c ? head_c.pc : '0;
   assign bus.instr_valid = valid_c;
   assign bus.busy        = (state_q == RUN);

endmodule
